// File: rtl/s1_syndrome_calc_pkg.sv
// Shared Reed-Solomon definitions for the decoder slice.
// GF(2^8) field polynomial, syndrome multiplier constants,
// syndrome count and the syndrome-stage FSM state type.
package rs_pkg;

    localparam logic [8:0]  GF_POLY = 9'h11D;
    localparam logic [7:0]  ALPHA1  = 8'h02;
    localparam logic [7:0]  ALPHA2  = 8'h04;
    localparam logic [7:0]  ALPHA3  = 8'h08;
    localparam int unsigned NSYN    = 4;

    // One-hot encoded syndrome-stage states
    typedef enum logic [1:0] {
        IDLE = 2'b01,
        ACC  = 2'b10
    } state_t;

endpackage

// File: rtl/s1_syndrome_calc_if.sv
// Symbol input stream for the syndrome stage.
//   in_valid : in_data carries a symbol this cycle
//   in_sop   : first symbol of a frame (qualified by in_valid)
//   in_data  : received symbol, highest degree first
// master drives the stream, slave (the syndrome stage) consumes it.
interface s1_syndrome_calc_if;

    logic       in_valid;
    logic       in_sop;
    logic [7:0] in_data;

    modport master (output in_valid, output in_sop, output in_data);
    modport slave  (input  in_valid, input  in_sop, input  in_data);

endinterface

// File: rtl/s1_syndrome_calc_gf2m8_multi.sv
// Combinational GF(2^8) multiplier, z = x * y mod GF_POLY.
//   x, y : operands
//   z    : product
// With a constant y the shift/add network collapses to XORs.
module gf2m8_multi
    import rs_pkg::*;
(
    input  logic [7:0] x,
    input  logic [7:0] y,
    output logic [7:0] z
);

    logic [7:0] prod;
    logic [7:0] term;

    always_comb begin
        prod = '0;
        term = x;
        for (int unsigned i = 0; i < 8; i++) begin
            if (y[i]) begin
                prod = prod ^ term;
            end
            term = {term[6:0], 1'b0} ^ (term[7] ? GF_POLY[7:0] : 8'h00);
        end
        z = prod;
    end

endmodule

// File: rtl/s1_syndrome_calc.sv
// First decoder stage: computes S_j = r(alpha^j), j = 0..3, of an
// RS(N, N-4) codeword over GF(2^8) using Horner's rule, one symbol per
// valid cycle.
//   clk, rstn            : clock, asynchronous active-low reset
//   in_if                : symbol stream (in_valid / in_sop / in_data)
//   rs_syn0..rs_syn3     : syndromes of the last completed frame
//   kes_ena              : one-cycle pulse, syndromes newly valid
//   syn_zero             : all syndromes of the last frame are zero
//   frame_err            : one-cycle pulse, frame aborted by early sop
// N must lie in 8..255 and 2^CW must exceed N.
module s1_syndrome_calc
    import rs_pkg::*;
#(
    parameter int unsigned N  = 255,
    parameter int unsigned CW = 8
)(
    input  logic               clk,
    input  logic               rstn,
    s1_syndrome_calc_if.slave  in_if,
    output logic [7:0]         rs_syn0,
    output logic [7:0]         rs_syn1,
    output logic [7:0]         rs_syn2,
    output logic [7:0]         rs_syn3,
    output logic               kes_ena,
    output logic               syn_zero,
    output logic               frame_err
);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [7:0]    acc_q [NSYN];
    logic [7:0]    acc_d [NSYN];
    logic [7:0]    mul_o [NSYN];
    logic [7:0]    syn_q [NSYN];

    logic load;      // sop accepted: frame (re)starts
    logic shift;     // in-frame symbol accepted
    logic last;      // accepted symbol completes the frame
    logic restart;   // sop arrived while a frame was open
    logic acc_zero;

    // alpha^0 = 1, so S0 needs no multiplier
    assign mul_o[0] = acc_q[0];

    gf2m8_multi u_mul1 (.x(acc_q[1]), .y(ALPHA1), .z(mul_o[1]));
    gf2m8_multi u_mul2 (.x(acc_q[2]), .y(ALPHA2), .z(mul_o[2]));
    gf2m8_multi u_mul3 (.x(acc_q[3]), .y(ALPHA3), .z(mul_o[3]));

    always_comb begin
        load     = in_if.in_valid & in_if.in_sop;
        shift    = in_if.in_valid & ~in_if.in_sop & (state_q == ACC);
        last     = shift & (cnt_q == CW'(N - 1));
        restart  = load & (state_q == ACC);
        acc_zero = 1'b1;
        for (int unsigned j = 0; j < NSYN; j++) begin
            acc_d[j] = load ? in_if.in_data : (mul_o[j] ^ in_if.in_data);
            if (acc_d[j] != 8'h00) begin
                acc_zero = 1'b0;
            end
        end

        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = ACC;
            ACC:     if (last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Accumulators and output buffer are separate, so a new frame may
    // load on the cycle right after the last symbol.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q     <= '0;
            kes_ena   <= 1'b0;
            syn_zero  <= 1'b0;
            frame_err <= 1'b0;
            for (int unsigned j = 0; j < NSYN; j++) begin
                acc_q[j] <= '0;
                syn_q[j] <= '0;
            end
        end else begin
            kes_ena   <= last;
            frame_err <= restart;
            if (load) begin
                cnt_q <= CW'(1);
            end else if (shift) begin
                cnt_q <= cnt_q + CW'(1);
            end
            for (int unsigned j = 0; j < NSYN; j++) begin
                if (load || shift) begin
                    acc_q[j] <= acc_d[j];
                end
                if (last) begin
                    syn_q[j] <= acc_d[j];
                end
            end
            if (last) begin
                syn_zero <= acc_zero;
            end
        end
    end

    assign rs_syn0 = syn_q[0];
    assign rs_syn1 = syn_q[1];
    assign rs_syn2 = syn_q[2];
    assign rs_syn3 = syn_q[3];

endmodule

// File: tb/tb_s1_syndrome_calc.sv
// Self-checking bench for s1_syndrome_calc (N = 255).
// Table of single-nonzero-symbol frames with known syndromes, random
// frames against a log/exp-table polynomial evaluation model, and
// hand-written sequences for back-to-back, early sop, ignored symbols
// in IDLE and mid-frame reset.
module tb_s1_syndrome_calc;

    localparam int N = 255;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] rs_syn0, rs_syn1, rs_syn2, rs_syn3;
    logic       kes_ena, syn_zero, frame_err;

    s1_syndrome_calc_if sif ();

    s1_syndrome_calc #(.N(N), .CW(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_if     (sif.slave),
        .rs_syn0   (rs_syn0),
        .rs_syn1   (rs_syn1),
        .rs_syn2   (rs_syn2),
        .rs_syn3   (rs_syn3),
        .kes_ena   (kes_ena),
        .syn_zero  (syn_zero),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pulse monitor, sampled on the falling edge
    int cyc = 0;
    int kes_cnt = 0;
    int ferr_cnt = 0;
    int kes_last = 0;
    int kes_prev = 0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (kes_ena) begin
            kes_cnt  <= kes_cnt + 1;
            kes_prev <= kes_last;
            kes_last <= cyc;
        end
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
    end

    // Reference model: r(x) evaluated at alpha^j via log/exp tables
    logic [7:0] exp_t [256];
    int         log_t [256];
    logic [7:0] fr [N];        // transmit order: fr[0] = r_{N-1}

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return exp_t[(log_t[a] + log_t[b]) % 255];
    endfunction

    function automatic logic [7:0] model_syn(input int j);
        logic [7:0] s;
        s = 8'h00;
        for (int k = 0; k < N; k++) begin
            s = s ^ gmul(fr[k], exp_t[(j * (N - 1 - k)) % 255]);
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3,
                              input logic ez, input logic ek);
        check({tag, " kes_ena"},  {7'd0, kes_ena},  {7'd0, ek});
        check({tag, " rs_syn0"},  rs_syn0, e0);
        check({tag, " rs_syn1"},  rs_syn1, e1);
        check({tag, " rs_syn2"},  rs_syn2, e2);
        check({tag, " rs_syn3"},  rs_syn3, e3);
        check({tag, " syn_zero"}, {7'd0, syn_zero}, {7'd0, ez});
    endtask

    task automatic idle();
        sif.in_valid = 1'b0;
        sif.in_sop   = 1'b0;
        sif.in_data  = 8'($urandom);
    endtask

    // Drive one accepted symbol with optional random idle cycles first.
    // Returns 1 time unit after the edge that captured it.
    task automatic drive_sym(input logic [7:0] d, input logic sop, input int gap);
        while (int'($urandom_range(0, 99)) < gap) begin
            idle();
            @(posedge clk); #1;
        end
        sif.in_valid = 1'b1;
        sif.in_sop   = sop;
        sif.in_data  = d;
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input int gap);
        for (int k = 0; k < N; k++) drive_sym(fr[k], k == 0, gap);
    endtask

    // Ends the pulse window: idle one cycle, kes_ena must have dropped
    task automatic end_frame(input string tag);
        idle();
        @(posedge clk); #1;
        check({tag, " kes_ena low"}, {7'd0, kes_ena}, 8'h00);
    endtask

    task automatic zero_frame();
        for (int k = 0; k < N; k++) fr[k] = 8'h00;
    endtask

    typedef struct {
        int         pos;       // degree of the single nonzero symbol
        logic [7:0] val;
        int         gap;       // idle-cycle probability in percent
        logic [7:0] e0, e1, e2, e3;
        logic       ez;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int k0, f0;
        logic [7:0] m [4];
        logic       mz;

        tbl[0] = '{0,   8'h00, 0,  8'h00, 8'h00, 8'h00, 8'h00, 1'b1};
        tbl[1] = '{0,   8'h5A, 0,  8'h5A, 8'h5A, 8'h5A, 8'h5A, 1'b0};
        tbl[2] = '{1,   8'h01, 0,  8'h01, 8'h02, 8'h04, 8'h08, 1'b0};
        tbl[3] = '{1,   8'h01, 40, 8'h01, 8'h02, 8'h04, 8'h08, 1'b0};
        tbl[4] = '{2,   8'h01, 0,  8'h01, 8'h04, 8'h10, 8'h40, 1'b0};
        tbl[5] = '{8,   8'h01, 25, 8'h01, 8'h1D, 8'h4C, 8'h8F, 1'b0};
        tbl[6] = '{254, 8'h01, 10, 8'h01, 8'h8E, 8'h47, 8'hAD, 1'b0};

        begin
            logic [8:0] x;
            x = 9'h001;
            log_t[0] = 0;
            for (int i = 0; i < 255; i++) begin
                exp_t[i] = x[7:0];
                log_t[x[7:0]] = i;
                x = {x[7:0], 1'b0};
                if (x[8]) x = x ^ 9'h11D;
            end
            exp_t[255] = exp_t[0];
        end

        idle();
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        check("reset frame_err", {7'd0, frame_err}, 8'h00);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Known single-symbol frames
        for (int i = 0; i < 7; i++) begin
            zero_frame();
            fr[N - 1 - tbl[i].pos] = tbl[i].val;
            k0 = kes_cnt;
            send_frame(tbl[i].gap);
            check_outs($sformatf("tbl%0d", i), tbl[i].e0, tbl[i].e1, tbl[i].e2, tbl[i].e3,
                       tbl[i].ez, 1'b1);
            end_frame($sformatf("tbl%0d", i));
            check($sformatf("tbl%0d kes count", i), 8'(kes_cnt - k0), 8'd1);
        end

        // Random frames against the model
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < N; k++) fr[k] = 8'($urandom);
            mz = 1'b1;
            for (int j = 0; j < 4; j++) begin
                m[j] = model_syn(j);
                if (m[j] != 8'h00) mz = 1'b0;
            end
            send_frame(15);
            check_outs($sformatf("rnd%0d", r), m[0], m[1], m[2], m[3], mz, 1'b1);
            end_frame($sformatf("rnd%0d", r));
        end

        // Valid symbols without sop in IDLE are dropped
        k0 = kes_cnt; f0 = ferr_cnt;
        for (int k = 0; k < 6; k++) drive_sym(8'hFF, 1'b0, 0);
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("idle drop kes", 8'(kes_cnt - k0), 8'd0);
        check("idle drop ferr", 8'(ferr_cnt - f0), 8'd0);
        check("idle drop hold", rs_syn0, m[0]);

        // Back-to-back: frame A (r_0 = 5A) then all-zero frame B
        zero_frame();
        fr[N - 1] = 8'h5A;
        send_frame(0);
        check_outs("b2b A", 8'h5A, 8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b1);
        zero_frame();
        for (int k = 0; k < N; k++) begin
            drive_sym(8'h00, k == 0, 0);
            if (k == 1 || k == 128 || k == N - 2)
                check_outs($sformatf("b2b hold%0d", k), 8'h5A, 8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b0);
        end
        check_outs("b2b B", 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
        end_frame("b2b B");
        check("b2b interval", 8'(kes_last - kes_prev), 8'(N));

        // Early sop at symbol index 100, outputs from a 5A frame first
        zero_frame();
        fr[N - 1] = 8'h5A;
        send_frame(0);
        end_frame("pre-abort");
        k0 = kes_cnt; f0 = ferr_cnt;
        for (int k = 0; k < 100; k++) drive_sym(8'h33, k == 0, 10);
        drive_sym(8'h00, 1'b1, 0);
        check("abort100 frame_err", {7'd0, frame_err}, 8'h01);
        check_outs("abort100 hold", 8'h5A, 8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b0);
        for (int k = 1; k < N; k++) begin
            drive_sym(8'h00, 1'b0, 0);
            if (k == 1) check("abort100 err pulse", {7'd0, frame_err}, 8'h00);
        end
        check_outs("abort100 restart", 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
        end_frame("abort100");
        check("abort100 kes count", 8'(kes_cnt - k0), 8'd1);
        check("abort100 ferr count", 8'(ferr_cnt - f0), 8'd1);

        // sop on the last slot aborts instead of completing
        k0 = kes_cnt;
        for (int k = 0; k < N - 1; k++) drive_sym(8'h11, k == 0, 0);
        drive_sym(8'h5A, 1'b1, 0);
        check("lastslot frame_err", {7'd0, frame_err}, 8'h01);
        check("lastslot no kes", {7'd0, kes_ena}, 8'h00);
        for (int k = 1; k < N; k++) drive_sym(8'h00, 1'b0, 5);
        // restarted frame: 5A at degree N-1 -> S_j = 5A * alpha^(j*254)
        check_outs("lastslot restart", 8'h5A, gmul(8'h5A, 8'h8E), gmul(8'h5A, 8'h47),
                   gmul(8'h5A, 8'hAD), 1'b0, 1'b1);
        end_frame("lastslot");
        check("lastslot kes count", 8'(kes_cnt - k0), 8'd1);

        // Reset mid-frame after a 5A frame
        zero_frame();
        fr[N - 1] = 8'h5A;
        send_frame(0);
        end_frame("pre-reset");
        for (int k = 0; k < 50; k++) drive_sym(8'h77, k == 0, 0);
        #2 rstn = 1'b0;
        #1;
        check_outs("midreset", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        check("midreset frame_err", {7'd0, frame_err}, 8'h00);
        idle();
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        zero_frame();
        send_frame(0);
        check_outs("post-reset", 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
        end_frame("post-reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
